left_shift_iter: RTL and testbench

Multicycle logical left shifter for the ALU shift path. It is the left-direction counterpart to the fixed arithmetic right-shift stages. It accepts a 32-bit operand and a 5-bit shift amount through a valid/ready handshake and applies one power-of-two stage per clock (1, 2, 4, 8, 16), LSB of shamt first. It returns the shifted word, a lost-ones flag and a signed-overflow flag. It sits between operand dispatch and the writeback mux, so the shift datapath needs only one stage of logic instead of a full barrel shifter.

---
 rtl/left_shift_iter_pkg.sv | 20 ++
 rtl/left_shift_stage.sv | 50 +++++
 rtl/left_shift_iter.sv | 122 ++++++++++++
 tb/tb_left_shift_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/left_shift_iter_pkg.sv
// Shared ALU shift-path definitions.
//   WIDTH      : operand/result width (fixed at 32 for this revision)
//   SHAMT_W    : shift-amount width, log2(WIDTH)
//   NUM_STAGES : number of power-of-two stages (1, 2, 4, 8, 16)
//   K_W        : width of the stage counter
//   state_t    : control FSM states of the iterative shifter
package left_shift_iter_pkg;

  localparam int WIDTH      = 32;
  localparam int SHAMT_W    = 5;
  localparam int NUM_STAGES = SHAMT_W;
  localparam int K_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/left_shift_stage.sv
// One power-of-two stage of the iterative left shifter (combinational).
//   acc      : current accumulator value
//   k        : stage index, shift distance is 2^k
//   en       : apply the stage (amt[k] set); when low acc passes through
//   sgn      : sign of the original operand
//   acc_next : accumulator after this stage
//   lost_bit : a 1 exits the top of the word in this stage
//   mism_bit : an exiting bit differs from the original sign
module left_shift_stage
  import left_shift_iter_pkg::*;
(
  input  logic [WIDTH-1:0] acc,
  input  logic [K_W-1:0]   k,
  input  logic             en,
  input  logic             sgn,
  output logic [WIDTH-1:0] acc_next,
  output logic             lost_bit,
  output logic             mism_bit
);

  // All five fixed-distance candidates are built in parallel; the stage
  // index only picks one, so every shift here is just wiring.
  logic [WIDTH-1:0] cand_acc  [NUM_STAGES];
  logic             cand_lost [NUM_STAGES];
  logic             cand_mism [NUM_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int STEP = 1 << gi;
      assign cand_acc[gi]  = acc << STEP;
      assign cand_lost[gi] = |acc[WIDTH-1 -: STEP];
      assign cand_mism[gi] = |(acc[WIDTH-1 -: STEP] ^ {STEP{sgn}});
    end
  endgenerate

  always_comb begin
    acc_next = acc;
    lost_bit = 1'b0;
    mism_bit = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (en && (k == i[K_W-1:0])) begin
        acc_next = cand_acc[i];
        lost_bit = cand_lost[i];
        mism_bit = cand_mism[i];
      end
    end
  end

endmodule

// File: rtl/left_shift_iter.sv
// Multicycle logical left shifter: one power-of-two stage per clock,
// LSB of shamt first, fixed 5-stage latency.
//   clock, reset_n       : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, shamt)
//   out_valid / out_ready: result handshake (shift, lost, ovf)
//   shift                : A << shamt, zero filled
//   lost                 : a 1 was shifted out of the top bit
//   ovf                  : result differs from A*2^shamt in two's complement
module left_shift_iter
  import left_shift_iter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   shift,
  output logic               lost,
  output logic               ovf
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   acc_reg;
  logic [SHAMT_W-1:0] amt_reg;
  logic [K_W-1:0]     k_reg;
  logic               sgn_reg;
  logic               lost_reg;
  logic               ovf_reg;

  logic               accept;
  logic               last_stage;
  logic               stage_en;
  logic [WIDTH-1:0]   stage_acc;
  logic               stage_lost;
  logic               stage_mism;

  assign accept     = in_valid & in_ready;
  assign last_stage = (k_reg == K_W'(NUM_STAGES - 1));
  assign stage_en   = (state_reg == SHIFT) & amt_reg[k_reg];

  left_shift_stage u_stage (
    .acc      (acc_reg),
    .k        (k_reg),
    .en       (stage_en),
    .sgn      (sgn_reg),
    .acc_next (stage_acc),
    .lost_bit (stage_lost),
    .mism_bit (stage_mism)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_stage) state_next = DONE;
      DONE: begin
        // A new operand may be taken on the same edge the result leaves.
        if (out_ready) state_next = accept ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: results are only exposed in DONE, everything else reads 0.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift     = '0;
    lost      = 1'b0;
    ovf       = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        shift     = acc_reg;
        lost      = lost_reg;
        // Exiting bits cover all but the final sign position; check it here.
        ovf       = ovf_reg | (acc_reg[WIDTH-1] != sgn_reg);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg  <= '0;
      amt_reg  <= '0;
      k_reg    <= '0;
      sgn_reg  <= 1'b0;
      lost_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      acc_reg  <= A;
      amt_reg  <= shamt;
      k_reg    <= '0;
      sgn_reg  <= A[WIDTH-1];
      lost_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (state_reg == SHIFT) begin
      acc_reg  <= stage_acc;
      lost_reg <= lost_reg | stage_lost;
      ovf_reg  <= ovf_reg | stage_mism;
      k_reg    <= k_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_left_shift_iter.sv
// Self-checking bench for left_shift_iter: expected results are computed
// with wide arithmetic when an operand is driven, queued, and compared when
// the DUT presents its result.
module tb_left_shift_iter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shift;
  logic        lost;
  logic        ovf;

  always #5 clock = ~clock;

  left_shift_iter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift     (shift),
    .lost      (lost),
    .ovf       (ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] shift;
    logic        lost;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: true product in 64 bits, compared with what fits in 32.
  task automatic push_exp(input logic [31:0] a, input logic [4:0] sh);
    exp_t        e;
    logic [63:0] uprod;
    logic [63:0] sprod;
    uprod   = {32'b0, a} << sh;
    sprod   = {{32{a[31]}}, a} << sh;
    e.a     = a;
    e.sh    = sh;
    e.shift = uprod[31:0];
    e.lost  = |uprod[63:32];
    e.ovf   = (sprod != {{32{uprod[31]}}, uprod[31:0]});
    exp_q.push_back(e);
  endtask

  task automatic drive_accept(input logic [31:0] a, input logic [4:0] sh);
    A        = a;
    shamt    = sh;
    in_valid = 1'b1;
    #1;
    check("in_ready_at_accept", 64'(in_ready), 64'd1);
    push_exp(a, sh);
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; waits for out_valid and compares.
  task automatic wait_and_compare(input int lat);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!out_valid && cycles < 30) begin
      step();
      cycles++;
    end
    check("latency", 64'(cycles), 64'(lat));
    check("sb_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("shift", 64'(shift), 64'(e.shift));
      check("lost",  64'(lost),  64'(e.lost));
      check("ovf",   64'(ovf),   64'(e.ovf));
      $display("txn A=0x%08h shamt=%0d -> shift=0x%08h lost=%0b ovf=%0b",
               e.a, e.sh, shift, lost, ovf);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_handshake", 64'(out_valid), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] sh);
    drive_accept(a, sh);
    wait_and_compare(5);
    release_result();
  endtask

  initial begin
    logic [31:0] held;
    logic        seen;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    shamt     = '0;
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_shift",     64'(shift),     64'd0);
    check("rst_lost",      64'(lost),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    run_op(32'h0000_0001, 5'd31);
    run_op(32'hFFFF_FFFF, 5'd4);
    run_op(32'h1234_5678, 5'd0);
    run_op(32'h4000_0000, 5'd1);
    run_op(32'hC000_0000, 5'd1);
    run_op(32'h8000_0000, 5'd0);
    run_op(32'hFFFF_FFFF, 5'd31);
    run_op(32'h7FFF_FFFF, 5'd16);
    for (int i = 0; i < 8; i++) begin
      run_op($urandom, 5'($urandom_range(0, 31)));
    end

    // Backpressure, then same-edge re-accept.
    drive_accept(32'h0000_00FF, 5'd8);
    wait_and_compare(5);
    held = shift;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_shift",     64'(shift),     64'(held));
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    drive_accept(32'h0000_0003, 5'd2);
    out_ready = 1'b0;
    check("bp_reaccept_out_valid", 64'(out_valid), 64'd0);
    wait_and_compare(5);
    release_result();

    // Asynchronous reset in the middle of stage k=2.
    A        = 32'h0000_000F;
    shamt    = 5'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_shift",     64'(shift),     64'd0);
    check("abort_lost",      64'(lost),      64'd0);
    check("abort_ovf",       64'(ovf),       64'd0);
    step();
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check("abort_no_result", 64'(seen), 64'd0);

    run_op(32'h0000_000F, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
